// File: rtl/mem_loader_pkg.sv
// Shared types for the memory loader: FSM state encoding and job mode constants.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_STREAM = 1'b0;
    localparam logic MODE_FILL   = 1'b1;

endpackage

// File: rtl/mem_loader_if.sv
// Job control, stream handshake and judge read port of the memory loader.
interface mem_loader_if #(
    parameter int W = 32,
    parameter int L = 16
);
    localparam int AW = $clog2(L);

    logic          start;
    logic          mode;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic [W-1:0]  fill_value;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  checksum;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;

    modport master (
        output start, mode, base_addr, count, fill_value, in_valid, in_data, rd_addr,
        input  in_ready, busy, done, checksum, rd_data
    );

    modport slave (
        input  start, mode, base_addr, count, fill_value, in_valid, in_data, rd_addr,
        output in_ready, busy, done, checksum, rd_data
    );

endinterface

// File: rtl/mem_loader_ram_sp.sv
// Single-port RAM: synchronous write, asynchronous read. Contents are never reset.
module ram_sp #(
    parameter int W = 32,
    parameter int L = 16
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [$clog2(L)-1:0] addr_i,
    input  logic [W-1:0]         wdata_i,
    output logic [W-1:0]         rdata_o
);
    logic [W-1:0] mem [L];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/mem_loader.sv
// Loads a window of the RAM from a valid/ready stream or with a constant fill,
// tracking a running checksum; the judge read port sees the RAM only while idle.
module mem_loader
    import loader_pkg::*;
#(
    parameter int W = 32,
    parameter int L = 16
) (
    input  logic         clk,
    input  logic         reset,
    mem_loader_if.slave  bus
);
    localparam int AW = $clog2(L);
    localparam logic [AW:0] L_CNT = (AW+1)'(L);

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [AW:0]   remain_q;
    logic          mode_q;
    logic [W-1:0]  fill_q;
    logic [W-1:0]  checksum_q;
    logic          busy_q;
    logic          done_q;
    logic          in_ready_q;

    logic [AW-1:0] addr_d;
    logic [AW:0]   remain_d;
    logic [W-1:0]  checksum_d;
    logic [AW:0]   count_clamped;
    logic          we;
    logic [W-1:0]  wdata;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_rdata;

    // Reset gates the write so a handshake coinciding with reset leaves memory untouched.
    always_comb begin
        count_clamped = (bus.count > L_CNT) ? L_CNT : bus.count;
        we            = busy_q && !reset && ((mode_q == MODE_FILL) || bus.in_valid);
        wdata         = (mode_q == MODE_FILL) ? fill_q : bus.in_data;
        addr_d        = addr_q + 1'b1;
        remain_d      = remain_q - 1'b1;
        checksum_d    = checksum_q + wdata;
        ram_addr      = busy_q ? addr_q : bus.rd_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            mode_q     <= MODE_STREAM;
            fill_q     <= '0;
            checksum_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        mode_q     <= bus.mode;
                        fill_q     <= bus.fill_value;
                        addr_q     <= bus.base_addr;
                        remain_q   <= count_clamped;
                        checksum_q <= '0;
                        if (count_clamped == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= LOAD;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                            in_ready_q <= (bus.mode == MODE_STREAM);
                        end
                    end
                end
                LOAD: begin
                    if (we) begin
                        addr_q     <= addr_d;
                        remain_q   <= remain_d;
                        checksum_q <= checksum_d;
                        if (remain_q == (AW+1)'(1)) begin
                            state_q    <= DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    ram_sp #(.W(W), .L(L)) u_ram (
        .clk     (clk),
        .we_i    (we),
        .addr_i  (ram_addr),
        .wdata_i (wdata),
        .rdata_o (ram_rdata)
    );

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.checksum = checksum_q;
    assign bus.rd_data  = busy_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: stream, wrapped stream with gaps, fill, zero/clamped
// counts, start ignored during a job, and reset in the middle of a job.
module tb_mem_loader;
    localparam int W  = 32;
    localparam int L  = 16;
    localparam int AW = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   n_busy;

    mem_loader_if #(.W(W), .L(L)) bus ();

    mem_loader #(.W(W), .L(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] w033 [8] = '{32'h00102283, 32'h00202303, 32'h00302383, 32'h00402403,
                              32'h006284B3, 32'h00838533, 32'h40A485B3, 32'h00B02023};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag, input int a, input logic [31:0] exp);
        bus.rd_addr = AW'(a);
        #1;
        check(tag, bus.rd_data, exp);
    endtask

    task automatic start_job(input logic m, input int base, input int cnt, input logic [31:0] fv);
        bus.start      = 1'b1;
        bus.mode       = m;
        bus.base_addr  = AW'(base);
        bus.count      = (AW+1)'(cnt);
        bus.fill_value = fv;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic count_busy();
        n_busy = 0;
        while (bus.busy === 1'b1 && n_busy < 40) begin
            n_busy++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.mode = 1'b0; bus.base_addr = '0; bus.count = '0;
        bus.fill_value = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.rd_addr = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_csum", bus.checksum, 32'd0);

        // Stream 8 words to 8..15
        start_job(1'b0, 8, 8, 32'h0);
        check("s1_busy", 32'(bus.busy), 32'd1);
        check("s1_ready", 32'(bus.in_ready), 32'd1);
        check("s1_rd_zero", bus.rd_data, 32'd0);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w033[i];
            tick();
        end
        bus.in_valid = 1'b0;
        check("s1_done", 32'(bus.done), 32'd1);
        check("s1_busy_end", 32'(bus.busy), 32'd0);
        check("s1_csum", bus.checksum, 32'h42DB3CC8);
        for (int i = 0; i < 8; i++) read_check("s1_mem", 8 + i, w033[i]);

        // Stream with gaps, wrapping 14,15,0,1
        start_job(1'b0, 14, 4, 32'h0);
        check("s2_done_clr", 32'(bus.done), 32'd0);
        for (int c = 0; c < 8; c++) begin
            check("s2_busy", 32'(bus.busy), 32'd1);
            check("s2_ready", 32'(bus.in_ready), 32'd1);
            bus.in_valid = (c % 2 == 1);
            bus.in_data  = (c % 2 == 1) ? 32'h11110001 + 32'(c / 2) : 32'hDEADBEEF;
            tick();
        end
        bus.in_valid = 1'b0;
        check("s2_busy_end", 32'(bus.busy), 32'd0);
        check("s2_done", 32'(bus.done), 32'd1);
        check("s2_csum", bus.checksum, 32'h4444000A);
        read_check("s2_m14", 14, 32'h11110001);
        read_check("s2_m15", 15, 32'h11110002);
        read_check("s2_m0", 0, 32'h11110003);
        read_check("s2_m1", 1, 32'h11110004);
        read_check("s2_m13", 13, 32'h00838533);
        read_check("s2_m12", 12, 32'h006284B3);

        // Fill whole memory
        start_job(1'b1, 0, 16, 32'hFFFFFF8D);
        check("f1_ready", 32'(bus.in_ready), 32'd0);
        count_busy();
        check("f1_busy_cycles", 32'(n_busy), 32'd16);
        check("f1_done", 32'(bus.done), 32'd1);
        check("f1_csum", bus.checksum, 32'hFFFFF8D0);
        for (int i = 0; i < 16; i++) read_check("f1_mem", i, 32'hFFFFFF8D);

        // Zero count: done at once, nothing written
        start_job(1'b1, 0, 0, 32'h12345678);
        check("z_busy", 32'(bus.busy), 32'd0);
        check("z_done", 32'(bus.done), 32'd1);
        check("z_csum", bus.checksum, 32'd0);
        read_check("z_m0", 0, 32'hFFFFFF8D);

        // Count 20 clamps to 16
        start_job(1'b1, 4, 20, 32'h00000100);
        check("c_done_clr", 32'(bus.done), 32'd0);
        count_busy();
        check("c_busy_cycles", 32'(n_busy), 32'd16);
        check("c_csum", bus.checksum, 32'h00001000);
        read_check("c_m3", 3, 32'h00000100);
        read_check("c_m0", 0, 32'h00000100);

        // Start during LOAD is ignored
        start_job(1'b0, 0, 4, 32'h0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h10000001;
        tick();
        bus.start = 1'b1; bus.mode = 1'b1; bus.base_addr = 4'd8; bus.count = 5'd2;
        bus.fill_value = 32'hCAFEF00D; bus.in_data = 32'h10000002;
        tick();
        bus.start = 1'b0; bus.mode = 1'b0;
        check("i_ready", 32'(bus.in_ready), 32'd1);
        bus.in_data = 32'h10000003;
        tick();
        bus.in_data = 32'h10000004;
        tick();
        bus.in_valid = 1'b0;
        check("i_done", 32'(bus.done), 32'd1);
        check("i_csum", bus.checksum, 32'h4000000A);
        read_check("i_m0", 0, 32'h10000001);
        read_check("i_m3", 3, 32'h10000004);
        read_check("i_m8", 8, 32'h00000100);

        // Reset after 3 of 8 writes
        start_job(1'b0, 4, 8, 32'h0);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h30000001 + 32'(i);
            tick();
        end
        bus.in_data = 32'h30000004;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        check("r_busy", 32'(bus.busy), 32'd0);
        check("r_done", 32'(bus.done), 32'd0);
        check("r_ready", 32'(bus.in_ready), 32'd0);
        check("r_csum", bus.checksum, 32'd0);
        read_check("r_m4", 4, 32'h30000001);
        read_check("r_m5", 5, 32'h30000002);
        read_check("r_m6", 6, 32'h30000003);
        read_check("r_m7", 7, 32'h00000100);
        read_check("r_m3", 3, 32'h10000004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
